// File: rtl/bias_loader.sv
// Bias register load sequencer: turns a valid/ready stream of signed bias words
// into one-hot single-lane writes, optionally zero-filling the lanes above the count.
module bias_loader #(
  parameter int ARRAY_N   = 16,
  parameter int OUT_WIDTH = 32
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_start,
  input  logic [$clog2(ARRAY_N):0]     i_lane_count,
  input  logic                         i_zero_fill,
  input  logic                         i_bias_valid,
  input  logic [OUT_WIDTH-1:0]         i_bias_data,
  output logic                         o_bias_ready,
  output logic [$clog2(ARRAY_N):0]     o_w_index,
  output logic [OUT_WIDTH-1:0]         o_w_data,
  output logic [ARRAY_N-1:0]           o_w_en,
  output logic                         o_busy,
  output logic                         o_done
);

  localparam int IW = $clog2(ARRAY_N) + 1;
  localparam logic [IW-1:0]      LANES   = IW'(ARRAY_N);
  localparam logic [IW-1:0]      LAST    = IW'(ARRAY_N - 1);
  localparam logic [ARRAY_N-1:0] ONE_HOT = ARRAY_N'(1);

  typedef enum logic [1:0] {IDLE, LOAD, FILL, DONE} state_t;

  state_t                 r_state;
  logic [IW-1:0]          r_cnt;
  logic [IW-1:0]          r_idx;
  logic                   r_zf;
  logic [IW-1:0]          r_w_index;
  logic signed [OUT_WIDTH-1:0] r_w_data;
  logic [ARRAY_N-1:0]     r_w_en;
  logic                   r_done;
  logic                   w_xfer;
  logic [ARRAY_N-1:0]     w_lane_en;

  // Ready depends on state alone, so no valid-to-ready combinational path.
  assign o_bias_ready = (r_state == LOAD);
  assign w_xfer       = o_bias_ready && i_bias_valid;
  assign w_lane_en    = ONE_HOT << r_idx[IW-2:0];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_zf      <= 1'b0;
      r_w_index <= '0;
      r_w_data  <= '0;
      r_w_en    <= '0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_w_en <= '0;
          r_done <= 1'b0;
          if (i_start) begin
            // A count of zero or beyond the array width means a full load.
            r_cnt   <= (i_lane_count == '0 || i_lane_count > LANES) ? LANES : i_lane_count;
            r_zf    <= i_zero_fill;
            r_idx   <= '0;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          if (w_xfer) begin
            r_w_en    <= w_lane_en;
            r_w_index <= r_idx;
            r_w_data  <= i_bias_data;
            r_idx     <= r_idx + IW'(1);
            if (r_idx == r_cnt - IW'(1)) begin
              if (r_zf && r_cnt < LANES) begin
                r_state <= FILL;
              end else begin
                r_state <= DONE;
                r_done  <= 1'b1;
              end
            end
          end else begin
            r_w_en <= '0;
          end
        end
        FILL: begin
          r_w_en    <= w_lane_en;
          r_w_index <= r_idx;
          r_w_data  <= '0;
          r_idx     <= r_idx + IW'(1);
          if (r_idx == LAST) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_w_en  <= '0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_w_index = r_w_index;
  assign o_w_data  = r_w_data;
  assign o_w_en    = r_w_en;
  assign o_done    = r_done;
  assign o_busy    = (r_state != IDLE);

endmodule
